evt_frame_scheduler: RTL and testbench

Master-side scheduler for one LIN event-triggered frame slot, sitting between the schedule table and the event-trigger response datapath. It requests the event-triggered header, enables the response merge path, and classifies the merged first response byte as a clean single response, silence, or collision. On collision it runs the LIN collision-resolution sequence, polling each associated unconditional frame in turn, then reports per-slave service status.

---
 rtl/evt_frame_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_evt_frame_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evt_frame_scheduler.sv
// LIN event-triggered frame slot scheduler: header request, response classification and,
// when EVT_COLL_RESOLVE_EN is defined, the collision-resolution poll of both slaves.
module evt_frame_scheduler #(
    parameter logic [5:0]  EVT_ID        = 6'h10,
    parameter logic [5:0]  UNCOND_FRAME1 = 6'h25,
    parameter logic [5:0]  UNCOND_FRAME2 = 6'h26,
    parameter logic [15:0] TIMEOUT_CYC   = 16'd200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       slot_start,
    output logic       hdr_req,
    output logic [7:0] hdr_pid,
    input  logic       hdr_ack,
    output logic       en_evenTrig_frame,
    input  logic       rx_valid,
    input  logic [9:0] rx_word,
    output logic       busy,
    output logic       collision_detected,
    output logic [1:0] served,
    output logic       timeout_err,
    output logic       resp_err,
    output logic       slot_done
);

    function automatic logic [7:0] lin_pid(input logic [5:0] id);
        logic p0;
        logic p1;
        p0 = id[0] ^ id[1] ^ id[2] ^ id[4];
        p1 = ~(id[1] ^ id[3] ^ id[4] ^ id[5]);
        return {p1, p0, id};
    endfunction

    localparam logic [7:0] EVT_PID = lin_pid(EVT_ID);
    localparam logic [5:0] POLL_ID [2] = '{UNCOND_FRAME1, UNCOND_FRAME2};

`ifdef EVT_COLL_RESOLVE_EN
    typedef enum logic [2:0] {
        S_IDLE, S_EVT_HDR, S_EVT_WAIT, S_RES1_HDR,
        S_RES1_WAIT, S_RES2_HDR, S_RES2_WAIT, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_EVT_HDR, S_EVT_WAIT, S_DONE
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        coll_q, coll_d;
    logic [1:0]  served_q, served_d;
    logic        tmo_q, tmo_d;
    logic        rerr_q, rerr_d;

    logic [7:0]  poll_pid  [2];
    logic [9:0]  poll_word [2];
    logic [1:0]  rx_match;
    logic        timer_expired;

    // Expected frame word of each slave: stop bit, PID, start bit (LSB first on the wire).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slave
            assign poll_pid[gi]  = lin_pid(POLL_ID[gi]);
            assign poll_word[gi] = {1'b1, poll_pid[gi], 1'b0};
            assign rx_match[gi]  = (rx_word == poll_word[gi]);
        end
    endgenerate

    assign timer_expired = (timer_q == (TIMEOUT_CYC - 16'd1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            timer_q  <= 16'd0;
            coll_q   <= 1'b0;
            served_q <= 2'b00;
            tmo_q    <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            coll_q   <= coll_d;
            served_q <= served_d;
            tmo_q    <= tmo_d;
            rerr_q   <= rerr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        coll_d   = coll_q;
        served_d = served_q;
        tmo_d    = tmo_q;
        rerr_d   = rerr_q;
        case (state_q)
            S_IDLE: begin
                if (slot_start) begin
                    state_d  = S_EVT_HDR;
                    coll_d   = 1'b0;
                    served_d = 2'b00;
                    tmo_d    = 1'b0;
                    rerr_d   = 1'b0;
                end
            end
            S_EVT_HDR: begin
                if (hdr_ack) begin
                    state_d = S_EVT_WAIT;
                    timer_d = 16'd0;
                end
            end
            S_EVT_WAIT: begin
                if (rx_valid) begin
                    if (rx_match[0]) begin
                        served_d[0] = 1'b1;
                        state_d     = S_DONE;
                    end else if (rx_match[1]) begin
                        served_d[1] = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        // Overlapping answers or a damaged frame both count as a collision.
                        coll_d = 1'b1;
`ifdef EVT_COLL_RESOLVE_EN
                        state_d = S_RES1_HDR;
`else
                        state_d = S_DONE;
`endif
                    end
                end else if (timer_expired) begin
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
`ifdef EVT_COLL_RESOLVE_EN
            S_RES1_HDR: begin
                if (hdr_ack) begin
                    state_d = S_RES1_WAIT;
                    timer_d = 16'd0;
                end
            end
            S_RES1_WAIT: begin
                if (rx_valid) begin
                    if (rx_match[0]) served_d[0] = 1'b1;
                    else             rerr_d      = 1'b1;
                    state_d = S_RES2_HDR;
                end else if (timer_expired) begin
                    tmo_d   = 1'b1;
                    state_d = S_RES2_HDR;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_RES2_HDR: begin
                if (hdr_ack) begin
                    state_d = S_RES2_WAIT;
                    timer_d = 16'd0;
                end
            end
            S_RES2_WAIT: begin
                if (rx_valid) begin
                    if (rx_match[1]) served_d[1] = 1'b1;
                    else             rerr_d      = 1'b1;
                    state_d = S_DONE;
                end else if (timer_expired) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from registered state only, so no input reaches an output combinationally.
    always_comb begin
        hdr_req           = 1'b0;
        hdr_pid           = 8'h00;
        en_evenTrig_frame = 1'b0;
        slot_done         = 1'b0;
        case (state_q)
            S_EVT_HDR: begin
                hdr_req = 1'b1;
                hdr_pid = EVT_PID;
            end
            S_EVT_WAIT: en_evenTrig_frame = 1'b1;
`ifdef EVT_COLL_RESOLVE_EN
            S_RES1_HDR: begin
                hdr_req = 1'b1;
                hdr_pid = poll_pid[0];
            end
            S_RES2_HDR: begin
                hdr_req = 1'b1;
                hdr_pid = poll_pid[1];
            end
`endif
            S_DONE:  slot_done = 1'b1;
            default: ;
        endcase
    end

    assign busy               = (state_q != S_IDLE);
    assign collision_detected = coll_q;
    assign served             = served_q;
    assign timeout_err        = tmo_q;
    assign resp_err           = rerr_q;

endmodule

// File: tb/tb_evt_frame_scheduler.sv
// Self-checking bench for evt_frame_scheduler: directed and randomized slots against a slot-level model.
module tb_evt_frame_scheduler;

    localparam int T = 200;
`ifdef EVT_COLL_RESOLVE_EN
    localparam bit RESOLVE = 1'b1;
`else
    localparam bit RESOLVE = 1'b0;
`endif
    localparam logic [9:0] W1      = 10'b1_00_100101_0;
    localparam logic [9:0] W2      = 10'b1_10_100110_0;
    localparam logic [7:0] PID_EVT = 8'h50;
    localparam logic [7:0] PID_1   = 8'h25;
    localparam logic [7:0] PID_2   = 8'hA6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       slot_start = 1'b0;
    logic       hdr_ack = 1'b0;
    logic       rx_valid = 1'b0;
    logic [9:0] rx_word = '0;
    logic       hdr_req, en_evenTrig_frame, busy, collision_detected;
    logic       timeout_err, resp_err, slot_done;
    logic [7:0] hdr_pid;
    logic [1:0] served;

    int errors = 0;
    int checks = 0;

    // Scenario description for one slot (phase 0 = event frame, 1/2 = resolution polls).
    int         ack_dly [3];
    bit         rsp_on  [3];
    int         rsp_dly [3];
    logic [9:0] rsp_word[3];
    int         ss_at;
    int         abort_ph;

    int         busy_n, en_n, done_n;
    bit         aborted;
    logic [7:0] pids[$];

    int         exp_busy, exp_en;
    logic [1:0] exp_served;
    logic       exp_coll, exp_tmo, exp_rerr;
    logic [7:0] exp_pids[$];

    evt_frame_scheduler dut (
        .clk               (clk),
        .reset             (reset),
        .slot_start        (slot_start),
        .hdr_req           (hdr_req),
        .hdr_pid           (hdr_pid),
        .hdr_ack           (hdr_ack),
        .en_evenTrig_frame (en_evenTrig_frame),
        .rx_valid          (rx_valid),
        .rx_word           (rx_word),
        .busy              (busy),
        .collision_detected(collision_detected),
        .served            (served),
        .timeout_err       (timeout_err),
        .resp_err          (resp_err),
        .slot_done         (slot_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "/hdr_req"}, 32'(hdr_req), 0);
        chk({tag, "/hdr_pid"}, 32'(hdr_pid), 0);
        chk({tag, "/en"}, 32'(en_evenTrig_frame), 0);
        chk({tag, "/busy"}, 32'(busy), 0);
        chk({tag, "/coll"}, 32'(collision_detected), 0);
        chk({tag, "/served"}, 32'(served), 0);
        chk({tag, "/tmo"}, 32'(timeout_err), 0);
        chk({tag, "/rerr"}, 32'(resp_err), 0);
        chk({tag, "/done"}, 32'(slot_done), 0);
    endtask

    task automatic clear_scn();
        for (int p = 0; p < 3; p++) begin
            ack_dly[p]  = 0;
            rsp_on[p]   = 1'b0;
            rsp_dly[p]  = 0;
            rsp_word[p] = '0;
        end
        ss_at    = -1;
        abort_ph = -1;
    endtask

    task automatic set_phase(input int p, input bit on, input int dly, input logic [9:0] w, input int ad);
        rsp_on[p]   = on;
        rsp_dly[p]  = dly;
        rsp_word[p] = w;
        ack_dly[p]  = ad;
    endtask

    function automatic logic [9:0] pick_word();
        logic [9:0] w;
        case ($urandom_range(0, 5))
            0:       w = W1;
            1:       w = W2;
            2:       w = W1 & W2;
            3:       w = W1 | 10'h001;
            4:       w = W2 & 10'h1FF;
            default: w = 10'($urandom);
        endcase
        return w;
    endfunction

    // Slot-level expectations: header list, flag outcome and slot length in cycles.
    task automatic model_slot();
        exp_pids.delete();
        exp_served = 2'b00;
        exp_coll   = 1'b0;
        exp_tmo    = 1'b0;
        exp_rerr   = 1'b0;
        exp_pids.push_back(PID_EVT);
        exp_busy = ack_dly[0] + 1 + 1;
        if (!rsp_on[0]) begin
            exp_en   = T;
            exp_busy += T;
        end else begin
            exp_en   = rsp_dly[0] + 1;
            exp_busy += rsp_dly[0] + 1;
            if (rsp_word[0] == W1)      exp_served = 2'b01;
            else if (rsp_word[0] == W2) exp_served = 2'b10;
            else begin
                exp_coll = 1'b1;
                if (RESOLVE) begin
                    for (int p = 1; p <= 2; p++) begin
                        exp_pids.push_back((p == 1) ? PID_1 : PID_2);
                        exp_busy += ack_dly[p] + 1;
                        if (!rsp_on[p]) begin
                            exp_busy += T;
                            exp_tmo  = 1'b1;
                        end else begin
                            exp_busy += rsp_dly[p] + 1;
                            if (rsp_word[p] == ((p == 1) ? W1 : W2)) exp_served[p-1] = 1'b1;
                            else                                     exp_rerr        = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic run_slot(input string tag);
        bit in_hdr, in_wait, ended;
        int hcnt, wcnt, cur_ph, hdr_n, guard, ad;
        in_hdr = 0; in_wait = 0; ended = 0;
        hcnt = 0; wcnt = 0; cur_ph = 0; hdr_n = 0; guard = 0;
        busy_n = 0; en_n = 0; done_n = 0; aborted = 0;
        pids.delete();
        model_slot();
        @(negedge clk); slot_start = 1'b1;
        @(negedge clk); slot_start = 1'b0;
        chk({tag, "/req_after_start"}, 32'(hdr_req), 1);
        while (!ended && guard < 3000) begin
            guard++;
            hdr_ack = 1'b0; rx_valid = 1'b0; slot_start = 1'b0;
            if (!busy) begin
                ended = 1;
            end else begin
                if (busy_n == ss_at) slot_start = 1'b1;
                busy_n++;
                if (slot_done) done_n++;
                if (en_evenTrig_frame) en_n++;
                if (abort_ph >= 0 && in_wait && cur_ph == abort_ph && wcnt == 5) begin
                    reset = 1'b0;
                    #1;
                    idle_outputs({tag, "/async_rst"});
                    @(negedge clk);
                    reset = 1'b1;
                    aborted = 1;
                    ended = 1;
                end else if (hdr_req) begin
                    if (!in_hdr) begin
                        in_hdr = 1; in_wait = 0; hcnt = 0;
                        pids.push_back(hdr_pid);
                    end
                    ad = (hdr_n < 3) ? ack_dly[hdr_n] : 0;
                    if (hcnt == ad) begin
                        hdr_ack = 1'b1;
                        in_hdr = 0; in_wait = 1; wcnt = 0;
                        cur_ph = (hdr_n < 3) ? hdr_n : 2;
                        hdr_n++;
                    end else begin
                        hcnt++;
                        rx_valid = 1'($urandom_range(0, 1));
                        rx_word  = 10'($urandom);
                    end
                end else if (in_wait) begin
                    if (rsp_on[cur_ph] && wcnt == rsp_dly[cur_ph]) begin
                        rx_valid = 1'b1;
                        rx_word  = rsp_word[cur_ph];
                        in_wait  = 0;
                    end
                    wcnt++;
                end
                if (!ended) @(negedge clk);
            end
        end
        hdr_ack = 1'b0; rx_valid = 1'b0; slot_start = 1'b0;
        if (!ended) chk({tag, "/terminated"}, 0, 1);
        if (!aborted) begin
            chk({tag, "/done_pulses"}, 32'(done_n), 1);
            chk({tag, "/busy_len"}, 32'(busy_n), 32'(exp_busy));
            chk({tag, "/en_len"}, 32'(en_n), 32'(exp_en));
            chk({tag, "/hdr_count"}, 32'(pids.size()), 32'(exp_pids.size()));
            for (int i = 0; i < exp_pids.size() && i < pids.size(); i++)
                chk($sformatf("%s/pid%0d", tag, i), 32'(pids[i]), 32'(exp_pids[i]));
            chk({tag, "/served"}, 32'(served), 32'(exp_served));
            chk({tag, "/coll"}, 32'(collision_detected), 32'(exp_coll));
            chk({tag, "/tmo"}, 32'(timeout_err), 32'(exp_tmo));
            chk({tag, "/rerr"}, 32'(resp_err), 32'(exp_rerr));
            chk({tag, "/req_idle"}, 32'(hdr_req), 0);
            chk({tag, "/done_idle"}, 32'(slot_done), 0);
        end
        $display("slot %s: served=%b coll=%b tmo=%b rerr=%b busy_cycles=%0d headers=%0d aborted=%0d",
                 tag, served, collision_detected, timeout_err, resp_err, busy_n, pids.size(), aborted);
    endtask

    initial begin
        clear_scn();
        repeat (3) @(negedge clk);
        idle_outputs("reset_hold");
        reset = 1'b1;
        @(negedge clk);
        idle_outputs("after_reset");

        for (int i = 0; i < 6; i++) begin
            hdr_ack  = 1'($urandom);
            rx_valid = 1'($urandom);
            rx_word  = 10'($urandom);
            @(negedge clk);
            chk("idle_ignores_inputs", 32'(busy), 0);
        end
        hdr_ack = 1'b0; rx_valid = 1'b0;

        clear_scn(); set_phase(0, 1, 3, W1, 0);
        run_slot("single_w1");

        clear_scn();
        set_phase(0, 1, 2, W1 & W2, 1);
        set_phase(1, 1, 4, W1, 0);
        set_phase(2, 1, 6, W2, 2);
        run_slot("collision");

        clear_scn(); set_phase(0, 0, 0, '0, 1);
        run_slot("silence");
        chk("silence_busy_203", 32'(busy_n), 203);

        clear_scn();
        set_phase(0, 1, 1, W2 | 10'h001, 0);
        set_phase(1, 0, 0, '0, 1);
        set_phase(2, 1, 3, W1, 0);
        run_slot("res_faults");

        clear_scn(); set_phase(0, 1, T - 1, W2, 0);
        run_slot("rx_at_timeout");

        clear_scn();
        set_phase(0, 1, 0, W1 & 10'h1FF, 0);
        set_phase(1, 1, T - 1, W1, 1);
        set_phase(2, 1, T - 1, W2, 0);
        run_slot("res_rx_at_timeout");

        clear_scn();
        set_phase(0, 1, 4, W1 & W2, 0);
        set_phase(1, 1, 2, W1, 0);
        set_phase(2, 1, 2, W1, 0);
        ss_at = 9;
        run_slot("start_while_busy");

        clear_scn(); set_phase(0, 1, 2, W2, 0); ss_at = 1;
        run_slot("start_in_hdr");

        clear_scn();
        set_phase(0, RESOLVE, 2, W1 & W2, 0);
        set_phase(1, 1, 1, W1, 0);
        abort_ph = RESOLVE ? 2 : 0;
        run_slot("rst_mid_slot");
        @(negedge clk);
        idle_outputs("after_abort");

        clear_scn(); set_phase(0, 1, 5, W2, 1);
        run_slot("clean_after_rst");

        for (int n = 0; n < 30; n++) begin
            clear_scn();
            for (int p = 0; p < 3; p++) begin
                ack_dly[p]  = $urandom_range(0, 3);
                rsp_on[p]   = ($urandom_range(0, 4) != 0);
                rsp_dly[p]  = ($urandom_range(0, 5) == 0) ? T - 1 : $urandom_range(0, 15);
                rsp_word[p] = pick_word();
            end
            ss_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 20) : -1;
            run_slot($sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
